tt_sweep_capture: RTL and testbench

- Sequential stimulus-and-capture stage for the lab's combinational exercise blocks.
- Drives every input combination of a 1–4 input exercise circuit in ascending binary order.
- Samples the single-bit output for each combination and builds its full truth table as a bitmap.
- Feeds the exercise circuit upstream and consumes its output downstream, replacing the hand-written delay-and-assign input sweeps with a clocked, self-timed sweep.

---
 rtl/tt_sweep_capture.sv | 127 ++++++++++++
 tb/tb_tt_sweep_capture.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: clocked stimulus-and-capture stage for combinational
// exercise circuits. It walks every input vector of an N_IN-input circuit in
// ascending order, waits SETTLE cycles per vector, and records the sampled
// output into a truth-table bitmap.
// Optional build macro TT_SWEEP_CHECK_EN adds comparison against exp_table
// with mismatch flag, saturating mismatch count and first-mismatch index.
module tt_sweep_capture #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   dut_y,
    input  logic [(1<<N_IN)-1:0]   exp_table,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   err,
    output logic [N_IN:0]          err_cnt,
    output logic [N_IN-1:0]        first_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Last vector of the sweep; the terminal compare stops vec_out here.
    localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
    // Counter value on which the settle wait ends (unused when SETTLE is 0).
    localparam logic [2:0]      SETTLE_LAST = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
    // With no settle time a new vector is sampled on the very next edge.
    localparam logic [1:0]      S_NEXT_VEC  = (SETTLE == 0) ? S_SAMPLE : S_WAIT;

    logic [1:0] state;
    logic [2:0] settle_cnt;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Sweep sequencer: vector stepping, settle timing and table capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec_out    <= '0;
            settle_cnt <= '0;
            table_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        table_out  <= '0;
                        vec_out    <= '0;
                        settle_cnt <= '0;
                        state      <= S_NEXT_VEC;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 3'd1;
                    end
                end
                S_SAMPLE: begin
                    table_out[vec_out] <= dut_y;
                    if (vec_out == VEC_LAST) begin
                        state <= S_DONE;
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        state   <= S_NEXT_VEC;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TT_SWEEP_CHECK_EN

    // Largest possible mismatch count: every vector of the sweep wrong.
    localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

    function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    logic mismatch;
    assign mismatch = (dut_y != exp_table[vec_out]);

    // Mismatch bookkeeping, cleared on sweep start and updated at each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
        end else if (state == S_IDLE && start) begin
            err       <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
        end else if (state == S_SAMPLE && mismatch) begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            if (!err) begin
                first_err <= vec_out;
            end
        end
    end

`else

    // Capture-only build: no comparison, expected table is ignored.
    logic unused_exp_table;
    assign unused_exp_table = ^exp_table;

    assign err       = 1'b0;
    assign err_cnt   = '0;
    assign first_err = '0;

`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: four instances cover the AND sweep,
// XOR sweep with injected expected-table errors, start-while-busy, reset
// mid-sweep and the minimal-width back-to-back case.
module tb_tt_sweep_capture;

`ifdef TT_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] tbl;
        logic        err;
        logic [4:0]  cnt;
        logic [3:0]  fe;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] start_v;

    // u3: 3-input AND, SETTLE=1
    logic [2:0] vec3;  logic busy3, done3, err3;  logic [7:0] table3;
    logic [3:0] cnt3;  logic [2:0] fe3;  logic y3;
    assign y3 = &vec3;
    // u4: 4-input XOR, SETTLE=1, expected table with bits 3 and 9 flipped
    logic [3:0] vec4;  logic busy4, done4, err4;  logic [15:0] table4;
    logic [4:0] cnt4;  logic [3:0] fe4;  logic y4;
    assign y4 = ^vec4;
    // uz: 4-input XOR, SETTLE=0
    logic [3:0] vecz;  logic busyz, donez, errz;  logic [15:0] tablez;
    logic [4:0] cntz;  logic [3:0] fez;  logic yz;
    assign yz = ^vecz;
    // u1: 1-input inverter, SETTLE=7
    logic [0:0] vec1;  logic busy1, done1, err1;  logic [1:0] table1;
    logic [1:0] cnt1;  logic [0:0] fe1;  logic y1;
    assign y1 = ~vec1[0];

    tt_sweep_capture #(.N_IN(3), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_y(y3), .exp_table(8'h80),
        .vec_out(vec3), .busy(busy3), .done(done3), .table_out(table3),
        .err(err3), .err_cnt(cnt3), .first_err(fe3));
    tt_sweep_capture #(.N_IN(4), .SETTLE(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_y(y4), .exp_table(16'h6B9E),
        .vec_out(vec4), .busy(busy4), .done(done4), .table_out(table4),
        .err(err4), .err_cnt(cnt4), .first_err(fe4));
    tt_sweep_capture #(.N_IN(4), .SETTLE(0)) uz (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_y(yz), .exp_table(16'h6996),
        .vec_out(vecz), .busy(busyz), .done(donez), .table_out(tablez),
        .err(errz), .err_cnt(cntz), .first_err(fez));
    tt_sweep_capture #(.N_IN(1), .SETTLE(7)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .dut_y(y1), .exp_table(2'b01),
        .vec_out(vec1), .busy(busy1), .done(done1), .table_out(table1),
        .err(err1), .err_cnt(cnt1), .first_err(fe1));

    logic [3:0]  done_v;
    logic [3:0]  err_v;
    logic [15:0] tbl_v [4];
    logic [4:0]  cnt_v [4];
    logic [3:0]  fe_v  [4];
    assign done_v = {done1, donez, done4, done3};
    assign err_v  = {err1, errz, err4, err3};
    assign tbl_v[0] = {8'h00, table3};
    assign tbl_v[1] = table4;
    assign tbl_v[2] = tablez;
    assign tbl_v[3] = {14'h0000, table1};
    assign cnt_v[0] = {1'b0, cnt3};
    assign cnt_v[1] = cnt4;
    assign cnt_v[2] = cntz;
    assign cnt_v[3] = {3'b000, cnt1};
    assign fe_v[0]  = {1'b0, fe3};
    assign fe_v[1]  = fe4;
    assign fe_v[2]  = fez;
    assign fe_v[3]  = {3'b000, fe1};

    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_n = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_done(input int idx, input int exp_edge, input string tag);
        int lim;
        lim = edge_n + 200;
        while (!done_v[idx] && edge_n < lim) tick();
        chk({tag, "_done_edge"}, edge_n, exp_edge);
    endtask

    task automatic sb_check(input int idx, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb observed=unexpected_done expected=no_done", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_table"},     tbl_v[idx], e.tbl);
        chk({tag, "_err"},       err_v[idx], e.err);
        chk({tag, "_err_cnt"},   cnt_v[idx], e.cnt);
        chk({tag, "_first_err"}, fe_v[idx],  e.fe);
    endtask

    initial begin
        int dcount;
        int dedge;
        int seen;

        // Reset state
        rst_n   = 1'b0;
        start_v = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec",   vec4,   0);
        chk("rst_busy",  busy4,  0);
        chk("rst_done",  done4,  0);
        chk("rst_table", table4, 0);
        chk("rst_err",   err4,   0);
        chk("rst_cnt",   cnt4,   0);
        chk("rst_fe",    fe4,    0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy3", busy3, 0);

        // 3-input AND, SETTLE=1
        sb.push_back('{tbl: 16'h0080, err: 1'b0, cnt: 5'd0, fe: 4'd0});
        start_v[0] = 1'b1;
        edge_n = -1;
        tick();
        start_v[0] = 1'b0;
        chk("and3_busy_e0", busy3, 1);
        chk("and3_vec_e0",  vec3,  0);
        tick();
        tick();
        chk("and3_vec_e2", vec3, 1);
        wait_done(0, 16, "and3");
        chk("and3_vec_done", vec3, 7);
        sb_check(0, "and3");
        tick();
        chk("and3_busy_after", busy3,  0);
        chk("and3_done_after", done3,  0);
        chk("and3_table_hold", table3, 8'h80);

        // 4-input XOR against an expected table with two wrong entries
        sb.push_back('{tbl: 16'h6996, err: CHK, cnt: CHK ? 5'd2 : 5'd0, fe: CHK ? 4'd3 : 4'd0});
        start_v[1] = 1'b1;
        edge_n = -1;
        tick();
        start_v[1] = 1'b0;
        wait_done(1, 32, "xor4");
        chk("xor4_busy_e32", busy4, 1);
        sb_check(1, "xor4");
        tick();
        chk("xor4_busy_e33", busy4, 0);

        // Reset in the middle of vector 6
        start_v[1] = 1'b1;
        edge_n = -1;
        tick();
        start_v[1] = 1'b0;
        while (vec4 != 4'd6 && edge_n < 50) tick();
        chk("mid_vec6",      vec4,   6);
        chk("mid_table_pre", table4, 16'h0016);
        chk("mid_err_pre",   err4,   CHK);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec",   vec4,   0);
        chk("mid_rst_busy",  busy4,  0);
        chk("mid_rst_done",  done4,  0);
        chk("mid_rst_table", table4, 0);
        chk("mid_rst_err",   err4,   0);
        chk("mid_rst_cnt",   cnt4,   0);
        chk("mid_rst_fe",    fe4,    0);
        seen = 0;
        repeat (3) begin
            tick();
            if (done4) seen++;
        end
        chk("mid_rst_no_done", seen, 0);
        #4;
        rst_n = 1'b1;
        sb.push_back('{tbl: 16'h6996, err: CHK, cnt: CHK ? 5'd2 : 5'd0, fe: CHK ? 4'd3 : 4'd0});
        start_v[1] = 1'b1;
        edge_n = -1;
        tick();
        start_v[1] = 1'b0;
        wait_done(1, 32, "resweep");
        sb_check(1, "resweep");
        tick();

        // SETTLE=0 with start pulses while busy and during DONE
        sb.push_back('{tbl: 16'h6996, err: 1'b0, cnt: 5'd0, fe: 4'd0});
        start_v[2] = 1'b1;
        edge_n = -1;
        tick();
        start_v[2] = 1'b0;
        dcount = 0;
        dedge  = -1;
        for (int e = 1; e <= 20; e++) begin
            start_v[2] = (e == 5 || e == 16 || e == 17);
            tick();
            if (donez) begin
                dcount++;
                dedge = edge_n;
                chk("busy_start_vec_done", vecz, 15);
                sb_check(2, "busy_start");
            end
            if (edge_n == 17) begin
                chk("busy_start_idle_e17", busyz, 0);
                chk("busy_start_vec_e17",  vecz,  15);
            end
        end
        start_v[2] = 1'b0;
        chk("busy_start_done_cnt",  dcount, 1);
        chk("busy_start_done_edge", dedge,  16);
        chk("busy_start_no_queue",  busyz,  0);

        // N_IN=1, SETTLE=7, back-to-back sweeps
        sb.push_back('{tbl: 16'h0001, err: 1'b0, cnt: 5'd0, fe: 4'd0});
        start_v[3] = 1'b1;
        edge_n = -1;
        tick();
        start_v[3] = 1'b0;
        wait_done(3, 16, "inv1");
        sb_check(3, "inv1");
        start_v[3] = 1'b1;
        tick();
        chk("b2b_busy_e17",  busy1,  0);
        chk("b2b_table_e17", table1, 2'b01);
        tick();
        start_v[3] = 1'b0;
        chk("b2b_busy_e18",  busy1,  1);
        chk("b2b_table_e18", table1, 0);
        chk("b2b_vec_e18",   vec1,   0);
        sb.push_back('{tbl: 16'h0001, err: 1'b0, cnt: 5'd0, fe: 4'd0});
        wait_done(3, 34, "inv1_b2b");
        sb_check(3, "inv1_b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
